// File: rtl/led_gray_sequencer.sv
// LED Gray-code sequencer: turns the AXI-written control byte into a free-running
// Gray count on the LEDs. Optional LED_WRAP_IRQ_EN adds a one-cycle wrap_irq pulse.
module led_gray_sequencer #(
    parameter int unsigned BASE_DIV = 5000000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             ctrl_wr,
    input  logic [7:0]       ctrl_data,
    output logic [CNT_W-1:0] led_out,
    output logic [CNT_W-1:0] count_bin,
    output logic             step_tick,
    output logic             wrap_flag,
`ifdef LED_WRAP_IRQ_EN
    output logic             wrap_irq,
`endif
    output logic             busy
);

    localparam int unsigned PER_W  = 32;
    localparam int unsigned RATE_W = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   presc_q, presc_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   led_d;
    logic               wrap_flag_d;
    logic               step_d;
    logic               wrap_step;
    logic               terminal;

    logic               wr_run;
    logic               wr_dir;
    logic               wr_clear;
    logic [RATE_W-1:0]  wr_rate;

    assign wr_run   = ctrl_data[0];
    assign wr_dir   = ctrl_data[1];
    assign wr_clear = ctrl_data[2];
    assign wr_rate  = ctrl_data[7:3];

    assign busy = (state_q == S_RUN);

    // Next-state and datapath; a control write always wins over a pending step
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        period_d    = period_q;
        dir_d       = dir_q;
        count_d     = count_bin;
        step_d      = 1'b0;
        wrap_step   = 1'b0;
        terminal    = (presc_q == (period_q - PER_W'(1)));

        if (ctrl_wr) begin
            dir_d    = wr_dir;
            period_d = PER_W'(BASE_DIV) * (PER_W'(wr_rate) + PER_W'(1));
            presc_d  = '0;
            state_d  = wr_run ? S_RUN : S_IDLE;
            if (wr_clear) begin
                count_d = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                end
                S_RUN: begin
                    if (terminal) begin
                        presc_d = '0;
                        step_d  = 1'b1;
                        if (dir_q) begin
                            count_d   = count_bin - CNT_W'(1);
                            wrap_step = (count_bin == '0);
                        end else begin
                            count_d   = count_bin + CNT_W'(1);
                            wrap_step = (count_bin == {CNT_W{1'b1}});
                        end
                    end else begin
                        presc_d = presc_q + PER_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        wrap_flag_d = ctrl_wr ? 1'b0 : (wrap_flag | wrap_step);
        led_d       = count_d ^ (count_d >> 1);
    end

    // All state and outputs update together so LEDs and binary count stay aligned
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            period_q  <= '0;
            dir_q     <= 1'b0;
            count_bin <= '0;
            led_out   <= '0;
            step_tick <= 1'b0;
            wrap_flag <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            period_q  <= period_d;
            dir_q     <= dir_d;
            count_bin <= count_d;
            led_out   <= led_d;
            step_tick <= step_d;
            wrap_flag <= wrap_flag_d;
        end
    end

`ifdef LED_WRAP_IRQ_EN
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wrap_irq <= 1'b0;
        end else begin
            wrap_irq <= wrap_step;
        end
    end
`endif

endmodule

// File: tb/tb_led_gray_sequencer.sv
// Scoreboard bench for led_gray_sequencer (BASE_DIV=4): expected steps are queued
// at each control write and matched against every step_tick the DUT produces.
module tb_led_gray_sequencer;

    localparam int unsigned BASE_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       ctrl_wr;
    logic [7:0] ctrl_data;
    logic [7:0] led_out;
    logic [7:0] count_bin;
    logic       step_tick;
    logic       wrap_flag;
    logic       busy;
`ifdef LED_WRAP_IRQ_EN
    logic       wrap_irq;
`endif

    led_gray_sequencer #(.BASE_DIV(BASE_DIV), .CNT_W(8)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .ctrl_wr       (ctrl_wr),
        .ctrl_data     (ctrl_data),
        .led_out       (led_out),
        .count_bin     (count_bin),
        .step_tick     (step_tick),
        .wrap_flag     (wrap_flag),
`ifdef LED_WRAP_IRQ_EN
        .wrap_irq      (wrap_irq),
`endif
        .busy          (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
        logic [7:0] led;
        logic       wrap;
        logic       irq;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    logic [7:0] exp_cnt = 8'h00;
    logic       exp_dir = 1'b0;
    logic       exp_wrap = 1'b0;
    int         exp_per = 0;
    int         exp_next = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [7:0] gray(input logic [7:0] c);
        return c ^ (c >> 1);
    endfunction

    // Monitor: every step must match the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (step_tick) begin
            if (sb.size() == 0) begin
                check("spurious_step", 32'(count_bin), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("step_cycle", 32'(cyc), 32'(e.cyc));
                check("step_count", 32'(count_bin), 32'(e.cnt));
                check("step_led", 32'(led_out), 32'(e.led));
                check("step_wrap", 32'(wrap_flag), 32'(e.wrap));
`ifdef LED_WRAP_IRQ_EN
                check("step_irq", 32'(wrap_irq), 32'(e.irq));
`endif
            end
        end
    end

    // Issue one control write; must be called at a falling edge
    task automatic load(input logic [7:0] d);
        ctrl_wr   = 1'b1;
        ctrl_data = d;
        @(negedge clk);
        ctrl_wr   = 1'b0;
        ctrl_data = 8'h00;
        exp_wrap  = 1'b0;
        exp_dir   = d[1];
        exp_per   = int'(BASE_DIV) * (int'(d[7:3]) + 1);
        exp_next  = cyc;
        if (d[2]) exp_cnt = 8'h00;
    endtask

    task automatic expect_steps(input int n);
        exp_t e;
        logic w;
        for (int i = 0; i < n; i++) begin
            exp_next += exp_per;
            if (exp_dir) begin
                w = (exp_cnt == 8'h00);
                exp_cnt = exp_cnt - 8'd1;
            end else begin
                w = (exp_cnt == 8'hFF);
                exp_cnt = exp_cnt + 8'd1;
            end
            exp_wrap = exp_wrap | w;
            e.cyc  = exp_next;
            e.cnt  = exp_cnt;
            e.led  = gray(exp_cnt);
            e.wrap = exp_wrap;
            e.irq  = w;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) until all queued steps have been seen
    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ctrl_wr   = 1'b1;
        ctrl_data = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        ctrl_wr   = 1'b0;
        ctrl_data = 8'h00;
        @(negedge clk);

        // 1: reset overrides the concurrent write
        check("rst_led", 32'(led_out), 32'h00);
        check("rst_count", 32'(count_bin), 32'h00);
        check("rst_step", 32'(step_tick), 32'h0);
        check("rst_wrap", 32'(wrap_flag), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef LED_WRAP_IRQ_EN
        check("rst_irq", 32'(wrap_irq), 32'h0);
`endif

        // 2: run up at rate 0
        load(8'h01);
        check("run_busy", 32'(busy), 32'h1);
        expect_steps(5);
        drain(60);

        // 3: clear while stopping, then count down from 0
        load(8'h04);
        check("clr_count", 32'(count_bin), 32'h00);
        check("clr_busy", 32'(busy), 32'h0);
        load(8'h03);
        expect_steps(1);
        drain(20);
        load(8'h00);
        check("stop_wrap", 32'(wrap_flag), 32'h0);
        check("stop_busy", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);
        check("hold_count", 32'(count_bin), 32'hFF);
        check("hold_led", 32'(led_out), 32'h80);

        // 4: rate 1 (period 8), then clear while running at rate 0
        load(8'h09);
        expect_steps(2);
        drain(40);
        load(8'h05);
        check("run_clr_count", 32'(count_bin), 32'h00);
        expect_steps(3);
        drain(40);

        // 5: write lands on the terminal prescaler cycle
        repeat (3) @(negedge clk);
        load(8'h01);
        check("coll_count", 32'(count_bin), 32'(exp_cnt));
        check("coll_step", 32'(step_tick), 32'h0);
        expect_steps(1);
        drain(20);

        // 6: full 256-step lap
        load(8'h05);
        expect_steps(256);
        drain(256 * 4 + 40);
        check("lap_count", 32'(count_bin), 32'h00);
        check("lap_led", 32'(led_out), 32'h00);
        check("lap_wrap", 32'(wrap_flag), 32'h1);
        load(8'h00);
        check("lap_wrap_clr", 32'(wrap_flag), 32'h0);
        repeat (8) @(negedge clk);
        check("final_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_gray_sequencer.md
Name: led_gray_sequencer

Overview:
Downstream consumer of the AXI-written LED control byte: takes the byte and its write strobe from the slave-register logic and drives the board LEDs with a free-running Gray-code count. The block provides a software-pollable binary count, a step pulse and a sticky wrap flag, which feed the read-side status register. Sits between the AXI slave user logic and the LED pins; one clock domain.

Parameters:
BASE_DIV, 5000000, clock cycles per step at rate field 0 (50 ms at 100 MHz); bench uses 4
CNT_W, 8, counter / LED width; fixed at 8 for this board

Ports:
S_AXI_ACLK  input  1  system clock, all logic on rising edge
S_AXI_ARESETN  input  1  synchronous active-low reset
ctrl_wr  input  1  one-cycle strobe: new control byte valid (AXI write to offset 0)
ctrl_data  input  8  control byte: [0] run, [1] dir (0 up, 1 down), [2] clear, [7:3] rate
led_out  output  8  Gray code of count, to LED pins
count_bin  output  8  binary count, for software polling
step_tick  output  1  one-cycle pulse on every count step
wrap_flag  output  1  sticky: count wrapped since last ctrl_wr
busy  output  1  high while in RUN state

Behaviour:
- Reset is synchronous and active-low: sampled only on the rising edge of S_AXI_ACLK while S_AXI_ARESETN=0. On reset, all outputs and internal state go to 0: led_out=0x00, count_bin=0x00, step_tick=0, wrap_flag=0, busy=0, state=IDLE, prescaler=0, latched control=0x00.
- Reset mid-run takes effect on the next edge and overrides ctrl_wr.
- Control latch: on ctrl_wr=1, latch run, dir and rate.
  - Period register = BASE_DIV*(rate+1), computed once at load; internal width 32 bits.
  - Prescaler cleared to 0; wrap_flag cleared.
  - If clear=1, count forced to 0x00 on the same edge.
- FSM, two states:
  - IDLE: count held, prescaler held at 0. On ctrl_wr with run=1, go to RUN.
  - RUN: prescaler increments each cycle. When prescaler = period-1: prescaler<=0, step taken, step_tick=1 for that cycle. On ctrl_wr with run=0, go to IDLE (count retained unless clear=1).
- Step arithmetic, modulo 256:
  - up: count+1; 0xFF->0x00 sets wrap_flag.
  - down: count-1; 0x00->0xFF sets wrap_flag.
- Output timing:
  - led_out = count ^ (count>>1), registered so led_out and count_bin change on the same edge.
  - First step occurs exactly period cycles after the edge that accepted ctrl_wr.
- Simultaneous ctrl_wr and terminal prescaler count: the load wins, the step is suppressed (no count change, no step_tick) and the prescaler restarts from 0.
- ctrl_wr with identical data while running still restarts the prescaler.
- busy = (state==RUN).

Optional Feature:
Macro: LED_WRAP_IRQ_EN.
- Defined: adds output port wrap_irq (1 bit). It pulses high for exactly one cycle on each wrap step, independent of the sticky wrap_flag.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
1. Hold S_AXI_ARESETN=0 for 3 cycles with ctrl_wr=1, ctrl_data=0xFF -> after release, all outputs 0, busy=0.
2. BASE_DIV=4; write 0x01 (run, up, rate 0) -> step_tick every 4 cycles, first step 4 cycles after write; led_out sequence 0x01,0x03,0x02,0x06,0x07; count_bin 1..5.
3. From count 0, write 0x03 (run, down) -> first step count_bin=0xFF, led_out=0x80, wrap_flag=1 (wrap_irq pulse if LED_WRAP_IRQ_EN); then write 0x00 -> wrap_flag=0, busy=0, count held at 0xFF.
4. Write 0x09 (run, rate 1) -> step period 8 cycles; then write 0x05 (run, clear) -> count 0x00 on next edge, stepping continues at period 4.
5. Issue ctrl_wr=0x01 on the exact cycle the prescaler reaches 3 -> no step that cycle, next step 4 cycles later.
6. Run up 256 steps from 0x00 -> count_bin=0x00, led_out=0x00, wrap_flag=1 set on step 256 only.
